// File: rtl/control_heroe.sv
`default_nettype none
// ============================================================================
// Module   : control_heroe
// Brief    : Hero control stage ahead of the character ROM. Turns raw player
//            buttons into a registered hero select (1..5) and movement code
//            (0 idle, 1 volar, 2 saltar, 3 agachar). Volar and saltar run for
//            a fixed number of game ticks; agachar lasts while held.
// Revision : 1.0 - initial release
// ============================================================================
module control_heroe #(
  parameter int TICK_DIV   = 5_000_000,
  parameter int DUR_VOLAR  = 10,
  parameter int DUR_SALTAR = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_sel,
  input  logic       btn_volar,
  input  logic       btn_saltar,
  input  logic       btn_agachar,
  output logic [2:0] heroe,
  output logic [1:0] mov,
  output logic       busy
);

  // Counter sized for the longest timed action, in clock cycles.
  localparam int DUR_MAX  = (DUR_VOLAR > DUR_SALTAR) ? DUR_VOLAR : DUR_SALTAR;
  localparam int CNT_SPAN = DUR_MAX * TICK_DIV;
  localparam int CW       = (CNT_SPAN > 1) ? $clog2(CNT_SPAN) : 1;

  localparam logic [CW-1:0] VOLAR_LAST  = CW'(DUR_VOLAR * TICK_DIV - 1);
  localparam logic [CW-1:0] SALTAR_LAST = CW'(DUR_SALTAR * TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);

  // Bit positions inside the button vectors.
  localparam int B_SEL     = 0;
  localparam int B_VOLAR   = 1;
  localparam int B_SALTAR  = 2;
  localparam int B_AGACHAR = 3;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_VOLAR   = 2'd1,
    S_SALTAR  = 2'd2,
    S_AGACHAR = 2'd3
  } state_t;

  logic [3:0]    btn_raw;
  logic [3:0]    sync1_q;
  logic [3:0]    sync2_q;
  // Agachar is level-sensitive, so only the three edge-triggered buttons
  // carry a previous-value flop.
  logic [2:0]    prev_q;
  logic [2:0]    rise;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    heroe_q, heroe_d;
  logic [1:0]    mov_q, mov_d;
  logic          busy_q, busy_d;

  assign btn_raw = {btn_agachar, btn_saltar, btn_volar, btn_sel};
  assign rise    = sync2_q[2:0] & ~prev_q;

  assign heroe = heroe_q;
  assign mov   = mov_q;
  assign busy  = busy_q;

  // Two-flop synchronizer plus previous-value flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q[2:0];
    end
  end

  // State, duration counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      heroe_q <= 3'd1;
      mov_q   <= 2'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      heroe_q <= heroe_d;
      mov_q   <= mov_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state, counter, hero select and output decode of the next state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    heroe_d = heroe_q;

    // Hero changes only from IDLE; edges seen during an action are lost.
    if ((state_q == S_IDLE) && rise[B_SEL]) begin
      heroe_d = (heroe_q >= 3'd5) ? 3'd1 : heroe_q + 3'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (rise[B_VOLAR]) begin
          state_d = S_VOLAR;
          cnt_d   = '0;
        end else if (rise[B_SALTAR]) begin
          state_d = S_SALTAR;
          cnt_d   = '0;
        end else if (sync2_q[B_AGACHAR]) begin
          state_d = S_AGACHAR;
        end
      end
      S_VOLAR: begin
        if (cnt_q == VOLAR_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_SALTAR: begin
        if (cnt_q == SALTAR_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_AGACHAR: begin
        if (!sync2_q[B_AGACHAR]) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs register the decode of the upcoming state so they change on
    // the same edge as the state itself.
    mov_d  = state_d;
    busy_d = (state_d != S_IDLE);
  end

endmodule
`default_nettype wire

// File: doc/control_heroe.md
# control_heroe

Hero control stage that sits directly upstream of the character ROM. It converts the player buttons into the registered `heroe` (character select, 1..5) and `mov` (0 idle, 1 volar, 2 saltar, 3 agachar) codes that the ROM consumes. Timed actions (volar, saltar) run for a fixed number of clock-divided ticks and then return to idle. Agachar is held for as long as its button is pressed.

## Interface
- `TICK_DIV`, default 5_000_000: clock cycles per game tick (0.1 s at 50 MHz).
- `DUR_VOLAR`, default 10: volar duration, in ticks.
- `DUR_SALTAR`, default 5: saltar duration, in ticks.
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `btn_sel` in 1: raw button, cycles the hero; asynchronous to `clk`.
- `btn_volar` in 1: raw button, starts volar.
- `btn_saltar` in 1: raw button, starts saltar.
- `btn_agachar` in 1: raw button, holds agachar.
- `heroe` out 3: selected hero, range 1..5; feeds the ROM `heroe` input.
- `mov` out 2: movement code; feeds the ROM `mov` input.
- `busy` out 1: high whenever `mov` != 0.

## Operation
- Input conditioning:
  - Each button passes through a 2-flop synchronizer, then a registered previous-value flop.
  - A rising edge is defined as synchronized=1 and previous=0.
  - There is no debounce; bouncing is handled upstream.
- `heroe` register:
  - Resets to 1.
  - A `btn_sel` rising edge while the FSM is in IDLE increments it, wrapping 5 -> 1.
  - `btn_sel` edges seen outside IDLE are dropped, not queued.
  - Values 0, 6 and 7 are never produced.
- FSM states and `mov` values: IDLE (0), VOLAR (1), SALTAR (2), AGACHAR (3). `mov` is a registered decode of the state.
- Transitions from IDLE (priority order; exactly one is taken per cycle):
  1. `btn_volar` rising edge -> VOLAR.
  2. `btn_saltar` rising edge -> SALTAR.
  3. Synchronized `btn_agachar` level high -> AGACHAR.
- A hero increment and an action entry in the same cycle both take effect.
- Duration counter:
  - On entry to VOLAR or SALTAR, the counter clears to 0 and increments every clock.
  - Exit to IDLE happens when the counter equals DUR*TICK_DIV-1.
  - VOLAR therefore lasts exactly DUR_VOLAR*TICK_DIV cycles; SALTAR lasts exactly DUR_SALTAR*TICK_DIV cycles.
  - Counter width is clog2(max(DUR_VOLAR, DUR_SALTAR)*TICK_DIV).
- AGACHAR: exits to IDLE in the cycle the synchronized `btn_agachar` reads 0. There is no minimum duration.
- Ignored inputs during an action: all action edges seen in VOLAR, SALTAR or AGACHAR are ignored. There is no chaining and no retrigger.
- Back-to-back actions: if `btn_agachar` is still held when VOLAR or SALTAR ends, the FSM enters AGACHAR from IDLE on the next cycle. IDLE is visible for one cycle in between.
- `busy` is registered and stays consistent with `mov` on every cycle.

## Timing
- Reset:
  - While `rst_n`=0: `heroe`=1, `mov`=0, `busy`=0, FSM in IDLE.
  - The duration counter and all synchronizer/previous flops are 0.
  - The reset takes effect asynchronously, including in the middle of an action.
  - After release, the first active edge behaves as IDLE with no pending edges.
- Input latency: a button first sampled high at edge E0 is seen by the FSM as a rising edge during cycle E1..E2. The new `mov`/`heroe`/`busy` value is visible after edge E2.
- Action length: `mov` holds 1 or 2 for exactly DUR*TICK_DIV clock cycles, then reads 0 after the following edge.
- Agachar release: `mov` returns to 0 two edges after release is first sampled, mirroring the entry latency.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Use TICK_DIV=4, DUR_VOLAR=3, DUR_SALTAR=2 for all scenarios.
- Reset then idle: assert and release `rst_n` -> `heroe`=1, `mov`=0, `busy`=0 for 20 cycles.
- Hero cycling: six `btn_sel` pulses, each 3 cycles high and 3 cycles low -> `heroe` goes 2,3,4,5,1,2. Each update appears 2 edges after the first high sample.
- Volar timing: pulse `btn_volar` -> `mov`=1 for exactly 12 cycles, then 0. A `btn_saltar` pulse and a `btn_sel` pulse at cycle 5 of the action have no effect; `heroe` is unchanged.
- Priority: `btn_volar` and `btn_saltar` rise in the same cycle -> `mov`=1. Hold `btn_agachar` throughout -> after the 12 cycles, `mov`=0 for 1 cycle, then 3 until release. `mov` returns to 0 two edges after release.
- Saltar and reset mid-action: start saltar (`mov`=2 for 8 cycles). Repeat, and drop `rst_n` at cycle 4 -> `mov`=0 and `heroe`=1 immediately. After release there is no residual action.
